// File: rtl/lock_key_ctrl_if.sv
// lock_key_ctrl_if: serial key-store stream into the lock controller
// master = secure key store, slave = lock_key_ctrl
interface lock_key_ctrl_if;
  logic key_sdata;
  logic key_svalid;
  logic key_sready;

  modport master (
    output key_sdata,
    output key_svalid,
    input  key_sready
  );

  modport slave (
    input  key_sdata,
    input  key_svalid,
    output key_sready
  );
endinterface

// File: rtl/lock_key_ctrl.sv
// lock_key_ctrl: serial key load + golden-vector self-test for a locked core
// Optional LOAD watchdog: define LOCK_KEY_CTRL_TIMEOUT_EN
module lock_key_ctrl #(
  parameter int KEY_W = 4,
  parameter int SETTLE_CYC = 4,
  parameter int NUM_VEC = 4,
  parameter logic [5*NUM_VEC-1:0] VEC_TBL = 20'h5D7E0,
  parameter logic [2*NUM_VEC-1:0] GOLD_TBL = 8'hF8,
  parameter int MAX_RETRY = 2,
  parameter int LOAD_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  lock_key_ctrl_if.slave   key,
  output logic [KEY_W-1:0] key_out,
  input  logic [4:0]       func_in,
  output logic [4:0]       ckt_in,
  input  logic [1:0]       ckt_out,
  output logic [1:0]       func_out,
  output logic             busy,
  output logic             unlocked,
  output logic             lockout,
  output logic [1:0]       fail_cnt
);

  localparam int BW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int VW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_APPLY = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_PASS  = 3'd4;
  localparam logic [2:0] S_FAIL  = 3'd5;
  localparam logic [2:0] S_LOCK  = 3'd6;

  if (SETTLE_CYC < 1 || SETTLE_CYC > 255 || LOAD_TIMEOUT < 1) begin : g_bad_cfg
    $error("lock_key_ctrl: SETTLE_CYC or LOAD_TIMEOUT out of range");
  end

  logic [2:0]       state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [7:0]       settle_q, settle_d;
  logic [1:0]       fail_q, fail_d;
  logic [4:0]       cur_vec;
  logic [1:0]       cur_gold;
  logic             xfer;

`ifdef LOCK_KEY_CTRL_TIMEOUT_EN
  localparam int WDW = $clog2(LOAD_TIMEOUT + 1);
  logic [WDW-1:0] wd_q, wd_d;
`endif

  assign cur_vec  = VEC_TBL[int'(vec_q)*5 +: 5];
  assign cur_gold = GOLD_TBL[int'(vec_q)*2 +: 2];
  assign xfer     = (state_q == S_LOAD) && key.key_svalid;

  // next-state: load, settle, check, retry/lockout
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shadow_d  = shadow_q;
    key_d     = key_q;
    vec_d     = vec_q;
    settle_d  = settle_q;
    fail_d    = fail_q;
`ifdef LOCK_KEY_CTRL_TIMEOUT_EN
    wd_d      = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          bit_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          shadow_d[bit_cnt_q] = key.key_sdata;
          if (bit_cnt_q == BW'(KEY_W-1)) begin
            key_d     = shadow_d;
            vec_d     = '0;
            settle_d  = 8'(SETTLE_CYC-1);
            bit_cnt_d = '0;
            state_d   = S_APPLY;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
`ifdef LOCK_KEY_CTRL_TIMEOUT_EN
        else if (wd_q == WDW'(LOAD_TIMEOUT-1)) begin
          state_d = S_FAIL;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_APPLY: begin
        if (settle_q == 8'd0) begin
          state_d = S_CHECK;
        end else begin
          settle_d = settle_q - 8'd1;
        end
      end
      S_CHECK: begin
        if (ckt_out != cur_gold) begin
          key_d   = '0;
          state_d = S_FAIL;
        end else if (vec_q == VW'(NUM_VEC-1)) begin
          state_d = S_PASS;
        end else begin
          vec_d    = vec_q + 1'b1;
          settle_d = 8'(SETTLE_CYC-1);
          state_d  = S_APPLY;
        end
      end
      S_FAIL: begin
        fail_d    = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;
        key_d     = '0;
        bit_cnt_d = '0;
        if (int'(fail_q) + 1 >= MAX_RETRY) begin
          state_d = S_LOCK;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_PASS:  state_d = S_PASS;
      S_LOCK:  state_d = S_LOCK;
      default: state_d = S_IDLE;
    endcase
  end

  // state registers; reset discards any partial shadow key
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shadow_q  <= '0;
      key_q     <= '0;
      vec_q     <= '0;
      settle_q  <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shadow_q  <= shadow_d;
      key_q     <= key_d;
      vec_q     <= vec_d;
      settle_q  <= settle_d;
      fail_q    <= fail_d;
    end
  end

`ifdef LOCK_KEY_CTRL_TIMEOUT_EN
  // idle-cycle watchdog for the serial load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`endif

  // core input mux and output gating
  always_comb begin
    ckt_in   = 5'd0;
    func_out = 2'd0;
    unique case (state_q)
      S_APPLY, S_CHECK: ckt_in = cur_vec;
      S_PASS: begin
        ckt_in   = func_in;
        func_out = ckt_out;
      end
      default: ckt_in = 5'd0;
    endcase
  end

  assign key.key_sready = (state_q == S_LOAD);
  assign key_out        = key_q;
  assign unlocked       = (state_q == S_PASS);
  assign lockout        = (state_q == S_LOCK);
  assign fail_cnt       = fail_q;
  assign busy           = (state_q == S_LOAD) || (state_q == S_APPLY) ||
                          (state_q == S_CHECK) || (state_q == S_FAIL);

endmodule

// File: tb/tb_lock_key_ctrl.sv
// tb_lock_key_ctrl: randomized bench for lock_key_ctrl with a c17 core model
// Define LOCK_KEY_CTRL_TIMEOUT_EN to also exercise the LOAD watchdog
module tb_lock_key_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] key_out;
  logic [4:0] func_in = 5'd0;
  logic [4:0] ckt_in;
  logic [1:0] ckt_out;
  logic [1:0] func_out;
  logic       busy;
  logic       unlocked;
  logic       lockout;
  logic [1:0] fail_cnt;

  int errs = 0;
  int checks = 0;
  int cyc = 0;

  logic [4:0] vec_t [4] = '{5'b00000, 5'b11111, 5'b10101, 5'b01011};
  logic [1:0] gold_t [4] = '{2'b00, 2'b10, 2'b11, 2'b11};

  lock_key_ctrl_if kif();

  lock_key_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .key      (kif),
    .key_out  (key_out),
    .func_in  (func_in),
    .ckt_in   (ckt_in),
    .ckt_out  (ckt_out),
    .func_out (func_out),
    .busy     (busy),
    .unlocked (unlocked),
    .lockout  (lockout),
    .fail_cnt (fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // locked c17: any nonzero key corrupts the outputs
  function automatic logic [1:0] core(input logic [4:0] x, input logic [3:0] k);
    logic n1, n2, n3, n6, n7, n10, n11, n16, n19;
    {n1, n2, n3, n6, n7} = x;
    n10 = ~(n1 & n3);
    n11 = ~(n3 & n6);
    n16 = ~(n2 & n11);
    n19 = ~(n11 & n7);
    return {~(n10 & n16), ~(n16 & n19)} ^ {k[3] | k[0], k[2] | k[1]};
  endfunction

  assign ckt_out = core(ckt_in, key_out);

  function automatic int first_bad(input logic [3:0] k);
    for (int i = 0; i < 4; i++)
      if (core(vec_t[i], k) != gold_t[i]) return i;
    return -1;
  endfunction

  function automatic logic [16:0] outs();
    return {key_out, ckt_in, func_out, kif.key_sready,
            busy, unlocked, lockout, fail_cnt};
  endfunction

  task automatic do_reset;
    rst_n = 1'b0;
    start = 1'b0;
    kif.key_svalid = 1'b0;
    kif.key_sdata = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_start(output int ts);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ts = cyc;
  endtask

  // mode 0: valid high, 1: toggling, 2: random
  task automatic stream_key(input logic [3:0] k, input int mode,
                            output int ld);
    int i;
    logic v, rdy;
    i = 0;
    ld = 0;
    while (i < 4 && ld < 200) begin
      v = (mode == 0) ? 1'b1 :
          (mode == 1) ? ((ld % 2) == 0) : 1'($urandom_range(0, 1));
      kif.key_svalid = v;
      kif.key_sdata = k[i];
      checks++;
      if (key_out !== 4'd0) begin
        errs++;
        $display("FAIL partial_key: key_out=%h required 0", key_out);
      end
      rdy = kif.key_sready;
      @(negedge clk);
      if (v && rdy) i++;
      ld++;
    end
    kif.key_svalid = 1'b0;
    checks++;
    if (key_out !== k) begin
      errs++;
      $display("FAIL key_apply: key_out=%h required %h", key_out, k);
    end
  endtask

  // res: 0 unlocked, 1 failed and reloading, 2 locked out
  task automatic wait_outcome(input int ts, input int ld, input logic [3:0] k,
                              input int prev, output int res);
    int f, n, exp_t, exp_f;
    f = first_bad(k);
    n = 0;
    res = -1;
    while (unlocked !== 1'b1 && int'(fail_cnt) == prev && n < 80) begin
      checks++;
      if (func_out !== 2'b00) begin
        errs++;
        $display("FAIL func_gate: func_out=%h required 0", func_out);
      end
      @(negedge clk);
      n++;
    end
    if (f < 0) begin
      exp_t = ld + 4 * (4 + 1);
      res = 0;
      checks++;
      if (unlocked !== 1'b1) begin
        errs++;
        $display("FAIL unlock: unlocked=%b required 1", unlocked);
      end
      checks++;
      if (cyc - ts != exp_t) begin
        errs++;
        $display("FAIL unlock_latency: %0d required %0d", cyc - ts, exp_t);
      end
      checks++;
      if (busy !== 1'b0 || fail_cnt !== 2'(prev)) begin
        errs++;
        $display("FAIL pass_flags: busy=%b fail_cnt=%0d required 0/%0d",
                 busy, fail_cnt, prev);
      end
    end else begin
      exp_t = ld + 5 * (f + 1) + 1;
      exp_f = (prev + 1 > 3) ? 3 : prev + 1;
      checks++;
      if (int'(fail_cnt) != exp_f) begin
        errs++;
        $display("FAIL fail_cnt: %0d required %0d", fail_cnt, exp_f);
      end
      checks++;
      if (cyc - ts != exp_t) begin
        errs++;
        $display("FAIL fail_latency: %0d required %0d", cyc - ts, exp_t);
      end
      checks++;
      if (key_out !== 4'd0 || unlocked !== 1'b0) begin
        errs++;
        $display("FAIL fail_key: key_out=%h unlocked=%b required 0/0",
                 key_out, unlocked);
      end
      if (exp_f >= 2) begin
        res = 2;
        checks++;
        if ({lockout, busy, kif.key_sready} !== 3'b100) begin
          errs++;
          $display("FAIL lock_flags: %b required 100",
                   {lockout, busy, kif.key_sready});
        end
      end else begin
        res = 1;
        checks++;
        if ({lockout, busy, kif.key_sready} !== 3'b011) begin
          errs++;
          $display("FAIL retry_flags: %b required 011",
                   {lockout, busy, kif.key_sready});
        end
      end
    end
  endtask

  task automatic check_func(input logic [3:0] k);
    for (int i = 0; i < 5; i++) begin
      func_in = (i == 0) ? 5'b10101 : 5'($urandom);
      #1;
      checks++;
      if (ckt_in !== func_in || func_out !== core(func_in, k)) begin
        errs++;
        $display("FAIL func_path: in=%h ckt_in=%h func_out=%h required %h",
                 func_in, ckt_in, func_out, core(func_in, k));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    func_in = 5'($urandom);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs() !== 17'd0) begin
      errs++;
      $display("FAIL reset: outputs=%h required 0", outs());
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 17'd0) begin
      errs++;
      $display("FAIL idle: outputs=%h required 0", outs());
    end
  endtask

  task automatic test_unlock;
    int ts, ld, res;
    do_reset();
    pulse_start(ts);
    stream_key(4'b0000, 0, ld);
    wait_outcome(ts, ld, 4'b0000, 0, res);
    check_func(4'b0000);
  endtask

  task automatic test_retry;
    int ts, ld, res;
    do_reset();
    pulse_start(ts);
    stream_key(4'b0010, 0, ld);
    wait_outcome(ts, ld, 4'b0010, 0, res);
    ts = cyc;
    stream_key(4'b0000, 0, ld);
    wait_outcome(ts, ld, 4'b0000, 1, res);
  endtask

  task automatic test_lockout;
    int ts, ld, res;
    logic [3:0] k;
    do_reset();
    pulse_start(ts);
    for (int a = 0; a < 2; a++) begin
      k = 4'($urandom_range(1, 15));
      stream_key(k, 2, ld);
      wait_outcome(ts, ld, k, a, res);
      ts = cyc;
    end
    pulse_start(ts);
    repeat (4) begin
      checks++;
      if ({lockout, fail_cnt, busy, kif.key_sready, unlocked} !== 6'b110000) begin
        errs++;
        $display("FAIL locked_hold: %b required 110000",
                 {lockout, fail_cnt, busy, kif.key_sready, unlocked});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_toggle;
    int ts, ld, res;
    logic [3:0] k;
    do_reset();
    k = 4'($urandom_range(1, 15));
    pulse_start(ts);
    stream_key(k, 1, ld);
    wait_outcome(ts, ld, k, 0, res);
  endtask

  task automatic test_reset_mid;
    int ts, ld, res, n;
    do_reset();
    pulse_start(ts);
    stream_key(4'b0000, 0, ld);
    n = 0;
    while (ckt_in !== vec_t[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ckt_in !== vec_t[2]) begin
      errs++;
      $display("FAIL reach_vec2: ckt_in=%h required %h", ckt_in, vec_t[2]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 17'd0) begin
      errs++;
      $display("FAIL async_reset: outputs=%h required 0", outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start(ts);
    stream_key(4'b0000, 0, ld);
    wait_outcome(ts, ld, 4'b0000, 0, res);
  endtask

  task automatic test_random;
    int ts, ld, res, nf;
    logic [3:0] k;
    for (int r = 0; r < 8; r++) begin
      do_reset();
      pulse_start(ts);
      nf = 0;
      res = 1;
      while (res == 1) begin
        k = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom);
        stream_key(k, 2, ld);
        wait_outcome(ts, ld, k, nf, res);
        nf++;
        ts = cyc;
      end
      if (res == 0) check_func(k);
    end
  endtask

`ifdef LOCK_KEY_CTRL_TIMEOUT_EN
  task automatic test_timeout;
    int ts;
    do_reset();
    pulse_start(ts);
    kif.key_svalid = 1'b0;
    repeat (64) @(negedge clk);
    checks++;
    if (fail_cnt !== 2'd0 || busy !== 1'b1) begin
      errs++;
      $display("FAIL wd_early: fail_cnt=%0d busy=%b required 0/1",
               fail_cnt, busy);
    end
    @(negedge clk);
    checks++;
    if (fail_cnt !== 2'd1 || kif.key_sready !== 1'b1 || lockout !== 1'b0) begin
      errs++;
      $display("FAIL wd_fire: fail_cnt=%0d sready=%b lockout=%b required 1/1/0",
               fail_cnt, kif.key_sready, lockout);
    end
  endtask
`endif

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    kif.key_svalid = 1'b0;
    kif.key_sdata = 1'b0;
    @(negedge clk);
    test_reset();
    test_unlock();
    test_retry();
    test_lockout();
    test_toggle();
    test_reset_mid();
    test_random();
`ifdef LOCK_KEY_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
